unstacker_arbiter: RTL and testbench
====================================

Name: unstacker_arbiter

Overview:
- Shares one 128-to-32-bit byte unstacker between NUM_REQ 128-bit block producers, e.g. the AES encrypt and decrypt cores.
- Grants requesters round-robin, holding each grant for up to BURST_LEN whole blocks.
- Forwards the granted block to the unstacker and counts the 4 drained 32-bit words per block.
- Tags every output word with its owner so the downstream streamer can route it.

Parameters:
NUM_REQ, 2, number of 128-bit requesters (2..4)
BURST_LEN, 1, max blocks served per grant before rotating (1..15)
ID_W, 1, width of owner tag, equals clog2(NUM_REQ)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
clr_i  in  1  sync clear: return to IDLE, pointer 0, clears unstacker
enable_i  in  1  global enable; low freezes all state
req_valid_i  in  NUM_REQ  per-requester block valid
req_data_i  in  128*NUM_REQ  blocks; requester i at [128*i+127:128*i]
req_ready_o  out  NUM_REQ  per-requester block accepted this cycle
ustk_valid_o  out  1  block valid to unstacker valid_i
ustk_data_o  out  128  block to unstacker word_i
ustk_ready_i  in  1  from unstacker ready_o
ustk_clr_o  out  1  to unstacker clr_i
ustk_enable_o  out  1  to unstacker enable_i
word_valid_i  in  1  unstacker valid_o (32-bit word handshake fired)
owner_o  out  ID_W  requester owning the word currently presented
word_idx_o  out  2  index 0..3 of the current word within its block
last_o  out  1  high with word_valid_i on word index 3
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_ni low, async) and clr_i (sync, priority over enable_i):
  - state=IDLE, rr_ptr=0, grant=0, word_cnt=0, burst_cnt=0.
  - All outputs 0 except ustk_enable_o=enable_i; ustk_clr_o=clr_i (combinational).
- enable_i low: all registers hold; ustk_valid_o and req_ready_o forced 0; ustk_enable_o=0.
- States:
  - IDLE: if any req_valid_i, latch grant = first valid index at or after rr_ptr, cyclic -> ISSUE; else stay.
  - ISSUE: ustk_valid_o=1, ustk_data_o=req_data_i[grant]. Transfer when ustk_ready_i=1: req_ready_o[grant]=1 that cycle, word_cnt=0 -> DRAIN. If req_valid_i[grant] drops before transfer, no transfer, grant released, go IDLE, rr_ptr unchanged.
  - DRAIN: ustk_valid_o=0. Each cycle word_valid_i=1: word_cnt++.
    - On word_cnt==3 with word_valid_i: burst_cnt++, then decide:
      - Continue -> ISSUE with same grant when burst_cnt+1 < BURST_LEN and req_valid_i[grant]=1.
      - Otherwise -> IDLE with rr_ptr=(grant+1) mod NUM_REQ and burst_cnt=0.
- Outputs:
  - req_ready_o is one-hot or zero; never asserted outside ISSUE.
  - At most one block is in flight in the unstacker; ustk_valid_o is never high in DRAIN.
  - owner_o=grant and word_idx_o=word_cnt, both valid in ISSUE and DRAIN.
  - last_o = (state==DRAIN) & word_valid_i & (word_cnt==3).
- Latency:
  - Request to ustk_valid_o: 1 cycle (IDLE registers grant).
  - Block turnaround within a burst: DRAIN exit to ISSUE, 1 cycle.
  - Rotation: DRAIN to IDLE to ISSUE, 2 cycles.
- Boundaries:
  - word_valid_i outside DRAIN is ignored; a bench assertion flags it as an error.
  - Simultaneous requests: rr_ptr decides. After serving i, the next grant goes to i+1 if valid.
  - Single requester continuously valid: granted repeatedly, BURST_LEN blocks per grant, 2-cycle gap between grants.
  - word_cnt and burst_cnt wrap only via the explicit resets above; no overflow possible.
  - Reset or clr_i mid-DRAIN: the partial block is dropped and the unstacker is cleared via ustk_clr_o. No req_ready_o is generated for the dropped block.

Test Plan:
- Reset, then req_valid_i=01 with data 0x00112233_44556677_8899AABB_CCDDEEFF, model unstacker -> ustk_valid_o 1 cycle later; req_ready_o=01 on accept; owner_o=0; word_idx_o 0,1,2,3; last_o on 4th word; busy_o falls 1 cycle after.
- Both requesters valid continuously, BURST_LEN=1 -> grants alternate 0,1,0,1; owner_o matches each 4-word group; no req_ready_o overlap.
- BURST_LEN=3, req 0 valid for 5 blocks, req 1 always valid -> grant pattern 0,0,0,1,1,1,0,0; burst continuation gap is 1 cycle.
- ustk_ready_i held 0 for 5 cycles in ISSUE -> ustk_valid_o and data stable, req_ready_o=0, then accepted on the cycle ready rises.
- clr_i pulsed after 2 words drained -> ustk_clr_o=1 same cycle; next cycle state IDLE, rr_ptr=0, word_idx_o=0, busy_o=0.
- enable_i low for 3 cycles mid-DRAIN with word_valid_i=0 -> word_cnt, grant and state unchanged; draining resumes at the same word_idx_o.

Source files
------------

// File: rtl/unstacker_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : unstacker_arbiter_if
// Description : Bundles the requester-side block handshake, the shared
//               unstacker handshake and the word-tagging outputs of
//               unstacker_arbiter.
//   clr_i          sync clear (returns arbiter to IDLE, clears unstacker)
//   enable_i       global enable; low freezes the arbiter
//   req_valid_i    per-requester block valid          [NUM_REQ]
//   req_data_i     requester i block at [128*i +: 128] [128*NUM_REQ]
//   req_ready_o    per-requester block accepted       [NUM_REQ]
//   ustk_valid_o   block valid to unstacker
//   ustk_data_o    block to unstacker                 [128]
//   ustk_ready_i   unstacker ready
//   ustk_clr_o     unstacker clear
//   ustk_enable_o  unstacker enable
//   word_valid_i   unstacker 32-bit word handshake fired
//   owner_o        requester owning the current word  [ID_W]
//   word_idx_o     word index within the block        [2]
//   last_o         last (4th) word of the block
//   busy_o         arbiter not idle
//   Modports: master = arbiter side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface unstacker_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    logic                     clr_i;
    logic                     enable_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [128*NUM_REQ-1:0]   req_data_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic                     ustk_valid_o;
    logic [127:0]             ustk_data_o;
    logic                     ustk_ready_i;
    logic                     ustk_clr_o;
    logic                     ustk_enable_o;
    logic                     word_valid_i;
    logic [ID_W-1:0]          owner_o;
    logic [1:0]               word_idx_o;
    logic                     last_o;
    logic                     busy_o;

    modport master (
        input  clr_i, enable_i, req_valid_i, req_data_i, ustk_ready_i, word_valid_i,
        output req_ready_o, ustk_valid_o, ustk_data_o, ustk_clr_o, ustk_enable_o,
               owner_o, word_idx_o, last_o, busy_o
    );

    modport slave (
        output clr_i, enable_i, req_valid_i, req_data_i, ustk_ready_i, word_valid_i,
        input  req_ready_o, ustk_valid_o, ustk_data_o, ustk_clr_o, ustk_enable_o,
               owner_o, word_idx_o, last_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/unstacker_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unstacker_arbiter
// Description : Round-robin arbiter sharing one 128-to-32-bit unstacker among
//               NUM_REQ block producers. Each grant is held for up to
//               BURST_LEN blocks; the four drained words of every block are
//               counted and tagged with their owner.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     unstacker_arbiter_if.master (handshakes, data, tags)
// Revision    : 1.0 - initial release
// ============================================================================
module unstacker_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int BURST_LEN = 1,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    unstacker_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0] grant_q,     grant_d;
    logic [1:0]      word_cnt_q,  word_cnt_d;
    logic [3:0]      burst_cnt_q, burst_cnt_d;

    logic [127:0]       w_blk [NUM_REQ];
    logic               w_active;
    logic               w_pick_found;
    logic [ID_W-1:0]    w_pick_idx;
    logic [ID_W-1:0]    w_next_ptr;
    logic               w_gvalid;
    logic [4:0]         w_burst_next;
    logic               w_ustk_valid;
    logic [NUM_REQ-1:0] w_req_ready;

    // Cyclic index reduction used by the round-robin search.
    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_blk[gi] = bus.req_data_i[128*gi +: 128];
        end
    endgenerate

    // Clear dominates enable: a cleared cycle neither advances nor handshakes.
    assign w_active     = bus.enable_i & ~bus.clr_i;
    assign w_gvalid     = bus.req_valid_i[grant_q];
    assign w_burst_next = {1'b0, burst_cnt_q} + 5'd1;
    assign w_next_ptr   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // First valid requester at or after rr_ptr, searching cyclically.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_pick_found && bus.req_valid_i[wrap_idx(int'(rr_ptr_q) + k)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = wrap_idx(int'(rr_ptr_q) + k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        word_cnt_d   = word_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        w_ustk_valid = 1'b0;
        w_req_ready  = '0;
        if (w_active) begin
            case (state_q)
                IDLE: begin
                    if (w_pick_found) begin
                        grant_d = w_pick_idx;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    // A withdrawn block is never offered, so the unstacker
                    // cannot accept it; the grant is simply released.
                    if (!w_gvalid) begin
                        burst_cnt_d = '0;
                        state_d     = IDLE;
                    end else begin
                        w_ustk_valid = 1'b1;
                        if (bus.ustk_ready_i) begin
                            w_req_ready[grant_q] = 1'b1;
                            word_cnt_d           = '0;
                            state_d              = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.word_valid_i) begin
                        if (word_cnt_q == 2'd3) begin
                            word_cnt_d = '0;
                            if ((w_burst_next < 5'(BURST_LEN)) && w_gvalid) begin
                                burst_cnt_d = w_burst_next[3:0];
                                state_d     = ISSUE;
                            end else begin
                                burst_cnt_d = '0;
                                rr_ptr_d    = w_next_ptr;
                                state_d     = IDLE;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else if (bus.clr_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            word_cnt_q  <= word_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Tag outputs read as zero while idle or being cleared.
    assign bus.ustk_valid_o  = w_ustk_valid;
    assign bus.ustk_data_o   = w_ustk_valid ? w_blk[grant_q] : '0;
    assign bus.req_ready_o   = w_req_ready;
    assign bus.ustk_clr_o    = bus.clr_i;
    assign bus.ustk_enable_o = bus.enable_i;
    assign bus.busy_o        = ~bus.clr_i & (state_q != IDLE);
    assign bus.owner_o       = bus.busy_o ? grant_q : '0;
    assign bus.word_idx_o    = bus.busy_o ? word_cnt_q : '0;
    assign bus.last_o        = ~bus.clr_i & (state_q == DRAIN) & bus.word_valid_i &
                               (word_cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_unstacker_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unstacker_arbiter
// Description : Self-checking bench. Instance A (BURST_LEN=1) is driven by a
//               per-cycle vector table; instance B (BURST_LEN=3) runs a
//               grant-pattern sequence against a small unstacker model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unstacker_arbiter;

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D1 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   bad_a    = 0;
    int   bad_b    = 0;

    always #5 clk = ~clk;

    unstacker_arbiter_if #(.NUM_REQ(2), .ID_W(1)) ifa ();
    unstacker_arbiter_if #(.NUM_REQ(2), .ID_W(1)) ifb ();

    unstacker_arbiter #(.NUM_REQ(2), .BURST_LEN(1), .ID_W(1)) u_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifa)
    );

    unstacker_arbiter #(.NUM_REQ(2), .BURST_LEN(3), .ID_W(1)) u_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifb)
    );

    // Protocol watch: word_valid_i only legal in DRAIN, req_ready_o one-hot or zero.
    always @(posedge clk) begin
        if (rst_n) begin
            if (ifa.word_valid_i && (u_a.state_q != 2'd2)) bad_a++;
            if ($countones(ifa.req_ready_o) > 1) bad_a++;
            if (ifb.word_valid_i && (u_b.state_q != 2'd2)) bad_b++;
            if ($countones(ifb.req_ready_o) > 1) bad_b++;
        end
    end

    typedef struct {
        logic [1:0] req;
        logic       rdy;
        logic       wv;
        logic       clr;
        logic       en;
        logic       e_uv;
        logic [1:0] e_rr;
        logic       e_own;
        logic [1:0] e_idx;
        logic       e_last;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic [1:0] req, input logic rdy, input logic wv,
                       input logic clr, input logic en, input logic e_uv,
                       input logic [1:0] e_rr, input logic e_own,
                       input logic [1:0] e_idx, input logic e_last, input logic e_busy);
        vec_t v;
        v.req = req; v.rdy = rdy; v.wv = wv; v.clr = clr; v.en = en;
        v.e_uv = e_uv; v.e_rr = e_rr; v.e_own = e_own; v.e_idx = e_idx;
        v.e_last = e_last; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] act;
        logic [9:0] exp_v;
        int         acc, acc0, bw, last_c;
        int         own_q[$];
        int         gap_q[$];
        int         exp_own[8];
        int         exp_gap[8];

        ifa.clr_i = 1'b0; ifa.enable_i = 1'b1; ifa.req_valid_i = '0;
        ifa.req_data_i = {D1, D0}; ifa.ustk_ready_i = 1'b0; ifa.word_valid_i = 1'b0;
        ifb.clr_i = 1'b0; ifb.enable_i = 1'b1; ifb.req_valid_i = '0;
        ifb.req_data_i = {D1, D0}; ifb.ustk_ready_i = 1'b0; ifb.word_valid_i = 1'b0;

        //   req   rdy  wv   clr  en  | uv   rr     own  idx    last busy
        row(2'b00, 0, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);   // reset state
        // single request from requester 0
        row(2'b01, 0, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        row(2'b01, 1, 0, 0, 1,  1, 2'b01, 0, 2'd0, 0, 1);
        row(2'b00, 0, 1, 0, 1,  0, 2'b00, 0, 2'd0, 0, 1);
        row(2'b00, 0, 1, 0, 1,  0, 2'b00, 0, 2'd1, 0, 1);
        row(2'b00, 0, 1, 0, 1,  0, 2'b00, 0, 2'd2, 0, 1);
        row(2'b00, 0, 1, 0, 1,  0, 2'b00, 0, 2'd3, 1, 1);
        row(2'b00, 0, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        // requester 1, unstacker not ready for 5 cycles
        row(2'b10, 0, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        for (int k = 0; k < 5; k++)
            row(2'b10, 0, 0, 0, 1,  1, 2'b00, 1, 2'd0, 0, 1);
        row(2'b10, 1, 0, 0, 1,  1, 2'b10, 1, 2'd0, 0, 1);
        for (int k = 0; k < 4; k++)
            row(2'b00, 0, 1, 0, 1,  0, 2'b00, 1, 2'(k), (k == 3), 1);
        row(2'b00, 0, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        // both valid: grant 0 then 1
        row(2'b11, 1, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        row(2'b11, 1, 0, 0, 1,  1, 2'b01, 0, 2'd0, 0, 1);
        for (int k = 0; k < 4; k++)
            row(2'b11, 1, 1, 0, 1,  0, 2'b00, 0, 2'(k), (k == 3), 1);
        row(2'b11, 1, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        row(2'b11, 1, 0, 0, 1,  1, 2'b10, 1, 2'd0, 0, 1);
        row(2'b11, 1, 1, 0, 1,  0, 2'b00, 1, 2'd0, 0, 1);
        row(2'b11, 1, 1, 0, 1,  0, 2'b00, 1, 2'd1, 0, 1);
        // clear after two words: pointer back to 0, so requester 0 wins next
        row(2'b11, 1, 0, 1, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        row(2'b11, 1, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        row(2'b11, 1, 0, 0, 1,  1, 2'b01, 0, 2'd0, 0, 1);
        row(2'b11, 1, 1, 0, 1,  0, 2'b00, 0, 2'd0, 0, 1);
        row(2'b11, 1, 1, 0, 1,  0, 2'b00, 0, 2'd1, 0, 1);
        // enable low mid-drain: frozen at word 2
        for (int k = 0; k < 3; k++)
            row(2'b11, 1, 0, 0, 0,  0, 2'b00, 0, 2'd2, 0, 1);
        row(2'b11, 1, 1, 0, 1,  0, 2'b00, 0, 2'd2, 0, 1);
        row(2'b11, 1, 1, 0, 1,  0, 2'b00, 0, 2'd3, 1, 1);
        row(2'b11, 1, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        // enable low in ISSUE: no offer, no accept
        row(2'b11, 1, 0, 0, 0,  0, 2'b00, 1, 2'd0, 0, 1);
        row(2'b11, 1, 0, 0, 1,  1, 2'b10, 1, 2'd0, 0, 1);
        for (int k = 0; k < 4; k++)
            row(2'b00, 0, 1, 0, 1,  0, 2'b00, 1, 2'(k), (k == 3), 1);
        // requester withdraws in ISSUE: released, pointer unchanged
        row(2'b01, 0, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        row(2'b00, 1, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 1);
        row(2'b11, 1, 0, 0, 1,  0, 2'b00, 0, 2'd0, 0, 0);
        row(2'b11, 1, 0, 0, 1,  1, 2'b01, 0, 2'd0, 0, 1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ifa.req_valid_i  = vecs[i].req;
            ifa.ustk_ready_i = vecs[i].rdy;
            ifa.word_valid_i = vecs[i].wv;
            ifa.clr_i        = vecs[i].clr;
            ifa.enable_i     = vecs[i].en;
            #2;
            act   = {ifa.ustk_valid_o, ifa.req_ready_o, ifa.owner_o, ifa.word_idx_o,
                     ifa.last_o, ifa.busy_o, ifa.ustk_clr_o, ifa.ustk_enable_o};
            exp_v = {vecs[i].e_uv, vecs[i].e_rr, vecs[i].e_own, vecs[i].e_idx,
                     vecs[i].e_last, vecs[i].e_busy, vecs[i].clr, vecs[i].en};
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL vec%0d {uv,rr,own,idx,last,busy,clr,en} got=%b want=%b",
                         i, act, exp_v);
            end
            if (vecs[i].e_uv) begin
                checks++;
                if (ifa.ustk_data_o !== (vecs[i].e_own ? D1 : D0)) begin
                    failures++;
                    $display("FAIL vec%0d data got=%h want=%h", i, ifa.ustk_data_o,
                             (vecs[i].e_own ? D1 : D0));
                end
            end
        end
        @(negedge clk);
        ifa.req_valid_i = '0; ifa.ustk_ready_i = 1'b0; ifa.word_valid_i = 1'b0;

        // Instance B: requester 0 supplies 5 blocks, requester 1 always valid.
        exp_own = '{0, 0, 0, 1, 1, 1, 0, 0};
        exp_gap = '{0, 1, 1, 2, 1, 1, 2, 1};
        acc = 0; acc0 = 0; bw = 0; last_c = -100;
        for (int c = 0; c < 300 && acc < 8; c++) begin
            @(negedge clk);
            ifb.req_valid_i  = {1'b1, (acc0 < 5)};
            ifb.ustk_ready_i = (bw == 0);
            ifb.word_valid_i = (bw > 0);
            #2;
            if (ifb.ustk_valid_o && ifb.ustk_ready_i) begin
                own_q.push_back(int'(ifb.owner_o));
                gap_q.push_back(c - last_c);
                acc++;
                if (ifb.owner_o == 1'b0) acc0++;
                bw = 4;
            end else if (ifb.word_valid_i) begin
                if (ifb.last_o !== (bw == 1)) bad_b++;
                if (ifb.last_o) last_c = c;
                bw--;
            end
        end
        ifb.req_valid_i = '0; ifb.word_valid_i = 1'b0;

        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= own_q.size()) begin
                failures++;
                $display("FAIL burst_owner%0d got=missing want=%0d", k, exp_own[k]);
            end else if (own_q[k] != exp_own[k]) begin
                failures++;
                $display("FAIL burst_owner%0d got=%0d want=%0d", k, own_q[k], exp_own[k]);
            end
            if (k >= 1) begin
                checks++;
                if (k >= gap_q.size()) begin
                    failures++;
                    $display("FAIL burst_gap%0d got=missing want=%0d", k, exp_gap[k]);
                end else if (gap_q[k] != exp_gap[k]) begin
                    failures++;
                    $display("FAIL burst_gap%0d got=%0d want=%0d", k, gap_q[k], exp_gap[k]);
                end
            end
        end

        repeat (2) @(negedge clk);
        checks++;
        if (bad_a != 0) begin
            failures++;
            $display("FAIL protocol_a violations got=%0d want=0", bad_a);
        end
        checks++;
        if (bad_b != 0) begin
            failures++;
            $display("FAIL protocol_b violations got=%0d want=0", bad_b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
